// File: rtl/rca_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : rca_operand_collector
// Description : Collects the five source operands of an RCA instruction from
//               the 2-port register-file read path over several beats and
//               queues complete requests {rs1..rs5, sel, id} in a small
//               output FIFO with a valid/ready handshake toward the RCA.
// Config      : RCA_COLLECTOR_BYPASS_EN - when defined, a request completing
//               into an empty FIFO is presented on out_* in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_operand_collector #(
  parameter int XLEN       = 32,
  parameter int NUM_RCAS   = 4,
  parameter int READ_PORTS = 2,
  parameter int NUM_OPS    = 5,
  parameter int DEPTH      = 2,
  parameter int ID_W       = 8,
  localparam int SEL_W     = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [SEL_W-1:0]             issue_sel,
  input  logic [ID_W-1:0]              issue_id,
  output logic                         issue_ready,
  input  logic                         opnd_valid,
  input  logic [READ_PORTS*XLEN-1:0]   opnd_data,
  output logic                         opnd_ready,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_OPS*XLEN-1:0]      out_rs,
  output logic [SEL_W-1:0]             out_sel,
  output logic [ID_W-1:0]              out_id,
  output logic                         busy
);

  localparam int BEATS  = (NUM_OPS + READ_PORTS - 1) / READ_PORTS;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t                              state_q, state_d;
  logic [BCNT_W-1:0]                   beat_cnt_q, beat_cnt_d;
  logic [NUM_OPS-1:0][XLEN-1:0]        ops_q, ops_d;
  logic [SEL_W-1:0]                    sel_q, sel_d;
  logic [ID_W-1:0]                     id_q, id_d;
  logic [DEPTH-1:0][NUM_OPS*XLEN-1:0]  fifo_rs_q, fifo_rs_d;
  logic [DEPTH-1:0][SEL_W-1:0]         fifo_sel_q, fifo_sel_d;
  logic [DEPTH-1:0][ID_W-1:0]          fifo_id_q, fifo_id_d;
  logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                    count_q, count_d;

  logic fifo_empty, fifo_full, fifo_pop;
  logic issue_fire, beat_fire, last_fire;
  logic push, bypass;

  // Handshakes: issue only when the finished request is guaranteed a FIFO slot
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == FULL_CNT);
    fifo_pop    = ~fifo_empty & out_ready;
    issue_ready = (state_q == S_IDLE) & (~fifo_full | fifo_pop);
    opnd_ready  = (state_q == S_COLLECT);
    issue_fire  = issue_valid & issue_ready;
    beat_fire   = opnd_valid & opnd_ready;
    last_fire   = beat_fire & (beat_cnt_q == LAST_BEAT);
    busy        = opnd_ready | ~fifo_empty;
`ifdef RCA_COLLECTOR_BYPASS_EN
    bypass      = fifo_empty & last_fire & ~flush;
    push        = last_fire & ~(bypass & out_ready);
`else
    bypass      = 1'b0;
    push        = last_fire;
`endif
  end

  // Collection FSM and operand assembly; ops_d already holds the last beat
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    ops_d      = ops_q;
    sel_d      = sel_q;
    id_d       = id_q;
    case (state_q)
      S_IDLE: begin
        if (issue_fire) begin
          state_d    = S_COLLECT;
          beat_cnt_d = '0;
          ops_d      = '0;
          sel_d      = issue_sel;
          id_d       = issue_id;
        end
      end
      S_COLLECT: begin
        if (beat_fire) begin
          // Operand slots past NUM_OPS have no destination and are dropped
          for (int k = 0; k < NUM_OPS; k++) begin
            for (int p = 0; p < READ_PORTS; p++) begin
              if (int'(beat_cnt_q) * READ_PORTS + p == k) begin
                ops_d[k] = opnd_data[p*XLEN +: XLEN];
              end
            end
          end
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
    endcase
    if (flush) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
    end
  end

  // Output FIFO bookkeeping; flush empties it regardless of push/pop
  always_comb begin
    fifo_rs_d  = fifo_rs_q;
    fifo_sel_d = fifo_sel_q;
    fifo_id_d  = fifo_id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_rs_d[wr_ptr_q]  = ops_d;
        fifo_sel_d[wr_ptr_q] = sel_q;
        fifo_id_d[wr_ptr_q]  = id_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, fifo_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head presentation: bypassed request first, else FIFO head, else zeros
  always_comb begin
    out_valid = 1'b0;
    out_rs    = '0;
    out_sel   = '0;
    out_id    = '0;
    if (bypass) begin
      out_valid = 1'b1;
      out_rs    = ops_d;
      out_sel   = sel_q;
      out_id    = id_q;
    end else if (~fifo_empty) begin
      out_valid = 1'b1;
      out_rs    = fifo_rs_q[rd_ptr_q];
      out_sel   = fifo_sel_q[rd_ptr_q];
      out_id    = fifo_id_q[rd_ptr_q];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      ops_q      <= '0;
      sel_q      <= '0;
      id_q       <= '0;
      fifo_rs_q  <= '0;
      fifo_sel_q <= '0;
      fifo_id_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      ops_q      <= ops_d;
      sel_q      <= sel_d;
      id_q       <= id_d;
      fifo_rs_q  <= fifo_rs_d;
      fifo_sel_q <= fifo_sel_d;
      fifo_id_q  <= fifo_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule
`default_nettype wire
